// File: rtl/wormhole_out_ctrl_if.sv
// Handshake bundle between one wormhole output controller and its surroundings:
// upstream input ports, the 4-way matrix arbiter and the downstream link.
// master: the environment side (inputs, arbiter result, returned credits).
// slave:  the output controller itself.
interface wormhole_out_ctrl_if #(
   parameter int unsigned FLIT_W = 34
);
   logic [3:0]          in_valid;
   logic [4*FLIT_W-1:0] in_flit;
   logic [3:0]          in_ready;
   logic [3:0]          arb_req;
   logic [3:0]          arb_gnt;
   logic                out_valid;
   logic [FLIT_W-1:0]   out_flit;
   logic                credit_in;
   logic                err;

   modport master (
      output in_valid, in_flit, arb_gnt, credit_in,
      input  in_ready, arb_req, out_valid, out_flit, err
   );

   modport slave (
      input  in_valid, in_flit, arb_gnt, credit_in,
      output in_ready, arb_req, out_valid, out_flit, err
   );
endinterface

// File: rtl/wormhole_out_ctrl.sv
// Per-output-port wormhole controller: gathers head-flit requests for the arbiter,
// locks the output to the granted input until its tail passes, meters flits against
// downstream credits and registers the outgoing flit.
// Optional sticky protocol error detection is built when WORMHOLE_ERR_CHECK_EN is defined.
module wormhole_out_ctrl #(
   parameter int unsigned FLIT_W     = 34,
   parameter int unsigned CREDIT_MAX = 4,
   parameter int unsigned CNT_W      = 3
) (
   input logic               clk,
   input logic               rst_n,
   wormhole_out_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CreditMax = CNT_W'(CREDIT_MAX);
   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e             state_q;
   logic [1:0]         owner_q;
   logic [CNT_W-1:0]   credits_q;
   logic               out_valid_q;
   logic [FLIT_W-1:0]  out_flit_q;

   logic [FLIT_W-1:0]  flit  [4];
   logic [1:0]         ftype [4];
   logic               credit_ok;
   logic               gnt_onehot;
   logic               gnt_ok;
   logic [3:0]         req;
   logic [3:0]         ready;
   logic [1:0]         sel;
   logic               xfer;
   logic [FLIT_W-1:0]  sel_flit;
   logic [1:0]         sel_type;

   // Split the packed input bus into per-port flits and their type fields.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         flit[i]  = bus.in_flit[i*FLIT_W +: FLIT_W];
         ftype[i] = flit[i][FLIT_W-1 -: 2];
      end
   end

   // Arbiter requests, grant qualification, ready generation and source select.
   always_comb begin
      credit_ok  = (credits_q != '0);
      gnt_onehot = (bus.arb_gnt != 4'b0000) && ((bus.arb_gnt & (bus.arb_gnt - 4'd1)) == 4'b0000);
      req        = 4'b0000;
      ready      = 4'b0000;
      gnt_ok     = 1'b0;
      sel        = owner_q;
      if (state_q == StIdle) begin
         for (int i = 0; i < 4; i++) begin
            req[i] = bus.in_valid[i] & ftype[i][0] & credit_ok;
         end
         // A malformed or unrequested grant is dropped rather than trusted.
         gnt_ok = gnt_onehot && ((bus.arb_gnt & ~req) == 4'b0000);
         if (gnt_ok) begin
            ready = bus.arb_gnt;
         end
         case (bus.arb_gnt)
            4'b0010: sel = 2'd1;
            4'b0100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel = 2'd0;
         endcase
      end else begin
         ready[owner_q] = credit_ok;
      end
      xfer     = |(bus.in_valid & ready);
      sel_flit = flit[sel];
      sel_type = ftype[sel];
   end

   assign bus.arb_req   = req;
   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_flit  = out_flit_q;

   // Lock FSM, credit counter and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         owner_q     <= 2'd0;
         credits_q   <= CreditMax;
         out_valid_q <= 1'b0;
         out_flit_q  <= '0;
      end else begin
         out_valid_q <= xfer;
         if (xfer) begin
            out_flit_q <= sel_flit;
         end
         // Simultaneous consume and return cancel out; returns saturate at the ceiling.
         if (xfer && !bus.credit_in) begin
            credits_q <= credits_q - CntOne;
         end else if (!xfer && bus.credit_in && (credits_q != CreditMax)) begin
            credits_q <= credits_q + CntOne;
         end
         unique case (state_q)
            StIdle: begin
               // Head+tail is a whole packet, so only a plain head takes the lock.
               if (xfer && (sel_type == 2'b01)) begin
                  state_q <= StLocked;
                  owner_q <= sel;
               end
            end
            StLocked: begin
               if (xfer && (sel_type == 2'b10)) begin
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

`ifdef WORMHOLE_ERR_CHECK_EN
   logic err_q;
   logic overflow;
   logic nested_head;

   assign overflow    = bus.credit_in && !xfer && (credits_q == CreditMax);
   assign nested_head = (state_q == StLocked) && bus.in_valid[owner_q] && ftype[owner_q][0];

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | overflow | nested_head;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_wormhole_out_ctrl.sv
// Bench for wormhole_out_ctrl: directed vector table, hand sequences for credit
// and reset corners, then randomized traffic against a rule-level reference model.
module tb_wormhole_out_ctrl;

   localparam int unsigned W   = 34;
   localparam int          MAX = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   wormhole_out_ctrl_if #(.FLIT_W(W)) bus ();

   wormhole_out_ctrl #(
      .FLIT_W     (W),
      .CREDIT_MAX (MAX),
      .CNT_W      (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model state
   bit           m_locked;
   int           m_owner;
   int           m_cred;
   bit           m_ov;
   logic [W-1:0] m_flit;
   bit           m_err;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] s_req;
   logic [3:0] s_ready;

   typedef struct {
      logic [3:0] v;
      logic [7:0] ty;
      logic [3:0] g;
      logic       c;
      logic [3:0] req;
      logic [3:0] rdy;
      logic       ov;
      logic [1:0] oty;
      int         oport;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [1:0] ty_of(input logic [4*W-1:0] f, input int i);
      return f[i*W + W-2 +: 2];
   endfunction

   function automatic logic [4*W-1:0] mk(input logic [7:0] ty, input logic [31:0] base);
      logic [4*W-1:0] r;
      for (int i = 0; i < 4; i++) r[i*W +: W] = {ty[2*i +: 2], base + 32'(i)};
      return r;
   endfunction

   function automatic logic [3:0] model_req(input logic [3:0] v, input logic [4*W-1:0] f);
      logic [3:0] r;
      logic [1:0] t;
      r = 4'b0000;
      if (!m_locked && m_cred > 0) begin
         for (int i = 0; i < 4; i++) begin
            t = ty_of(f, i);
            if (v[i] && t[0]) r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] model_ready(input logic [3:0] v, input logic [4*W-1:0] f,
                                             input logic [3:0] g);
      logic [3:0] r;
      logic [3:0] q;
      r = 4'b0000;
      if (m_locked) begin
         if (m_cred > 0) r[m_owner] = 1'b1;
      end else begin
         q = model_req(v, f);
         if ($countones(g) == 1 && (g & ~q) == 4'b0000) r = g;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_locked = 0;
      m_owner  = 0;
      m_cred   = MAX;
      m_ov     = 0;
      m_flit   = '0;
      m_err    = 0;
   endtask

   // One clock cycle: drive, check combinational outputs, advance model, check registers.
   task automatic cycle(input logic [3:0] v, input logic [4*W-1:0] f, input logic [3:0] g,
                        input logic c);
      logic [3:0] e_req;
      logic [3:0] e_rdy;
      logic [1:0] t;
      bit         xfer;
      int         win;
      bus.in_valid  = v;
      bus.in_flit   = f;
      bus.arb_gnt   = g;
      bus.credit_in = c;
      e_req = model_req(v, f);
      e_rdy = model_ready(v, f, g);
      #2;
      s_req   = bus.arb_req;
      s_ready = bus.in_ready;
      check("arb_req", s_req, e_req);
      check("in_ready", s_ready, e_rdy);
      xfer = |(v & e_rdy);
      win  = 0;
      for (int i = 0; i < 4; i++) if (v[i] && e_rdy[i]) win = i;
      if (c && !xfer && m_cred == MAX) m_err = 1;
      if (m_locked) begin
         t = ty_of(f, m_owner);
         if (v[m_owner] && t[0]) m_err = 1;
      end
      if (xfer && !c) m_cred--;
      else if (c && !xfer && m_cred < MAX) m_cred++;
      m_ov = xfer;
      if (xfer) begin
         m_flit = f[win*W +: W];
         t = ty_of(f, win);
         if (!m_locked && t == 2'b01) begin
            m_locked = 1;
            m_owner  = win;
         end else if (m_locked && t == 2'b10) begin
            m_locked = 0;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", bus.out_valid, m_ov);
      check("out_flit", bus.out_flit, m_flit);
`ifdef WORMHOLE_ERR_CHECK_EN
      check("err", bus.err, m_err);
`else
      check("err", bus.err, 1'b0);
`endif
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      bus.in_valid  = 4'b0000;
      bus.in_flit   = '0;
      bus.arb_gnt   = 4'b0000;
      bus.credit_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_flit", bus.out_flit, '0);
      check("rst_err", bus.err, 1'b0);
      check("rst_arb_req", bus.arb_req, 4'b0000);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0]   last;
      logic [W-1:0]   ef;
      logic [4*W-1:0] f;
      logic [3:0]     v;
      logic [3:0]     g;
      logic [3:0]     q;
      logic           c;
      int             cnt;
      int             k;
      int             r;

      tbl[0] = '{4'b0101, 8'b00_01_00_01, 4'b0100, 1'b0, 4'b0101, 4'b0100, 1'b1, 2'b01, 2};
      tbl[1] = '{4'b0101, 8'b00_00_00_01, 4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'b00, 2};
      tbl[2] = '{4'b0101, 8'b00_10_00_01, 4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'b10, 2};
      tbl[3] = '{4'b0001, 8'b00_00_00_01, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'b01, 0};
      tbl[4] = '{4'b0001, 8'b00_00_00_10, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'b10, 0};
      tbl[5] = '{4'b1000, 8'b11_00_00_00, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 2'b11, 3};
      tbl[6] = '{4'b0010, 8'b00_00_11_00, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'b11, 1};
      tbl[7] = '{4'b0010, 8'b00_00_01_00, 4'b0011, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'b00, 0};
      tbl[8] = '{4'b0010, 8'b00_00_01_00, 4'b0100, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'b00, 0};
      tbl[9] = '{4'b0001, 8'b00_00_00_00, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 0};

      @(posedge clk);
      #1;
      do_reset();

      // Directed vectors: arbitration, lock, tail release, single-flit packets, bad grants.
      last = '0;
      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].v, mk(tbl[i].ty, 32'hC0DE_0000), tbl[i].g, tbl[i].c);
         check($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
         check($sformatf("tbl%0d_rdy", i), s_ready, tbl[i].rdy);
         check($sformatf("tbl%0d_ov", i), bus.out_valid, tbl[i].ov);
         ef = tbl[i].ov ? {tbl[i].oty, 32'hC0DE_0000 + 32'(tbl[i].oport)} : last;
         check($sformatf("tbl%0d_flit", i), bus.out_flit, ef);
         last = ef;
      end

      // Credit exhaustion: 4 flits go out, then one credit releases exactly one more.
      do_reset();
      cycle(4'b0010, mk(8'b00_00_01_00, 32'h1000_0000), 4'b0010, 1'b0);
      cnt = 1;
      for (int i = 0; i < 4; i++) begin
         cycle(4'b0010, mk(8'h00, 32'h1000_0010 + 32'(i)), 4'b0000, 1'b0);
         if (s_ready[1]) cnt++;
      end
      check("cred_exhaust_count", 32'(cnt), 32'd4);
      cycle(4'b0010, mk(8'h00, 32'h1000_0020), 4'b0000, 1'b1);
      check("cred_zero_ready", s_ready, 4'b0000);
      cycle(4'b0010, mk(8'h00, 32'h1000_0030), 4'b0000, 1'b0);
      check("cred_one_ready", s_ready, 4'b0010);
      check("cred_one_out", bus.out_valid, 1'b1);
      cycle(4'b0010, mk(8'h00, 32'h1000_0040), 4'b0000, 1'b0);
      check("cred_again_zero", s_ready, 4'b0000);

      // Simultaneous transfer and credit return at credits=2, then overflow at ceiling.
      do_reset();
      cycle(4'b0001, mk(8'b00_00_00_01, 32'h2000_0000), 4'b0001, 1'b0);
      cycle(4'b0001, mk(8'h00, 32'h2000_0010), 4'b0000, 1'b0);
      cycle(4'b0001, mk(8'h00, 32'h2000_0020), 4'b0000, 1'b1);
      check("both_ready", s_ready, 4'b0001);
      cycle(4'b0001, mk(8'h00, 32'h2000_0030), 4'b0000, 1'b0);
      check("both_drain1", s_ready, 4'b0001);
      cycle(4'b0001, mk(8'h00, 32'h2000_0040), 4'b0000, 1'b0);
      check("both_drain2", s_ready, 4'b0001);
      cycle(4'b0001, mk(8'h00, 32'h2000_0050), 4'b0000, 1'b0);
      check("both_empty", s_ready, 4'b0000);
      for (int i = 0; i < 4; i++) cycle(4'b0000, '0, 4'b0000, 1'b1);
      check("pre_ovf_err", bus.err, 1'b0);
      cycle(4'b0000, '0, 4'b0000, 1'b1);
`ifdef WORMHOLE_ERR_CHECK_EN
      check("ovf_err", bus.err, 1'b1);
`else
      check("ovf_err", bus.err, 1'b0);
`endif

      // Reset mid-packet while locked with one credit left.
      do_reset();
      cycle(4'b0100, mk(8'b00_01_00_00, 32'h3000_0000), 4'b0100, 1'b0);
      cycle(4'b0100, mk(8'h00, 32'h3000_0010), 4'b0000, 1'b0);
      cycle(4'b0100, mk(8'h00, 32'h3000_0020), 4'b0000, 1'b0);
      check("pre_rst_ov", bus.out_valid, 1'b1);
      do_reset();
      cycle(4'b0100, mk(8'h00, 32'h3000_0030), 4'b0000, 1'b0);
      check("post_rst_stall", s_ready, 4'b0000);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1000, mk(8'b11_00_00_00, 32'h3000_0100 + 32'(i)), 4'b1000, 1'b0);
         if (s_ready[3]) cnt++;
      end
      check("post_rst_credits", 32'(cnt), 32'd4);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         if (n % 500 == 0) do_reset();
         v = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            f[i*W +: W] = {2'($urandom_range(0, 3)), 32'($urandom)};
         end
         q = model_req(v, f);
         r = $urandom_range(0, 9);
         if (r < 7 && q != 4'b0000) begin
            do k = $urandom_range(0, 3); while (!q[k]);
            g = 4'b0001 << k;
         end else if (r < 9) begin
            g = 4'b0000;
         end else begin
            g = 4'($urandom);
         end
         if (m_cred < MAX) c = 1'($urandom_range(0, 1));
         else c = ($urandom_range(0, 99) == 0);
         cycle(v, f, g, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
